// File: rtl/bsg_tx_core.sv
// Baseband TX core: bus register file, binary->Gray encoder and PAM-4 modulator with interrupt.
// Optional feature macro: BSG_GRAY_EN (defined = Gray encoder in the data path, undefined = raw binary).
module bsg_tx_core #(
  parameter int unsigned SYM_CYCLES = 4,
  parameter logic [7:0]  IDLE_LEVEL = 8'h80
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic       escrita,
  input  logic [1:0] endereco,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       ready,
  output logic [7:0] OUT,
  output logic       BSG_INT
);

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 2;
  localparam int unsigned CYC_W = (SYM_CYCLES > 1) ? $clog2(SYM_CYCLES) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(SYM_CYCLES - 1);

  localparam logic [AW-1:0] ADDR_CTRL  = 2'd0;
  localparam logic [AW-1:0] ADDR_DATA0 = 2'd1;
  localparam logic [AW-1:0] ADDR_DATA1 = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BYTE0 = 2'd1,
    S_BYTE1 = 2'd2
  } state_t;

  state_t           state_q, state_n;
  logic             txen_q, intmsk_q, intflag_q;
  logic [DW-1:0]    data0_q, data1_q;
  logic [DW-1:0]    snap0_q, snap1_q;
  logic [CYC_W-1:0] cyc_q, cyc_n;
  logic [1:0]       dib_q, dib_n;
  logic [DW-1:0]    out_n;
  logic             snap_load;
  logic             tx_done;

  logic             xfer_c, wr_c, rd_c, ctrl_wr_c, busy_c, sym_last_c;
  logic [DW-1:0]    rdata_c, cur_byte_c;

  function automatic logic [DW-1:0] encode(input logic [DW-1:0] b);
`ifdef BSG_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  // Dibit idx (0 = MSB pair) replicated four times gives 00/55/AA/FF.
  function automatic logic [DW-1:0] pam4_level(input logic [DW-1:0] b, input logic [1:0] idx);
    logic [1:0] d;
    case (idx)
      2'd0:    d = b[7:6];
      2'd1:    d = b[5:4];
      2'd2:    d = b[3:2];
      default: d = b[1:0];
    endcase
    return {4{d}};
  endfunction

  assign xfer_c     = valid & ~ready;
  assign wr_c       = xfer_c & escrita;
  assign rd_c       = xfer_c & ~escrita;
  assign ctrl_wr_c  = wr_c & (endereco == ADDR_CTRL);
  assign busy_c     = (state_q != S_IDLE);
  assign sym_last_c = (cyc_q == CYC_LAST) && (dib_q == 2'd3);
  assign cur_byte_c = (state_q == S_BYTE1) ? snap1_q : snap0_q;
  assign BSG_INT    = intflag_q & intmsk_q;

  always_comb begin
    rdata_c = '0;
    case (endereco)
      ADDR_CTRL:  rdata_c = {4'd0, busy_c, intflag_q, intmsk_q, txen_q};
      ADDR_DATA0: rdata_c = data0_q;
      ADDR_DATA1: rdata_c = data1_q;
      default:    rdata_c = '0;
    endcase
  end

  // Bus handshake: one-cycle ready pulse, read data only while ready is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready    <= 1'b0;
      data_out <= '0;
    end else begin
      ready    <= xfer_c;
      data_out <= rd_c ? rdata_c : 8'h00;
    end
  end

  // Register file; completion clears TXENABLE and sets INTFLAG over any same-edge write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txen_q    <= 1'b0;
      intmsk_q  <= 1'b0;
      intflag_q <= 1'b0;
      data0_q   <= '0;
      data1_q   <= '0;
    end else begin
      if (tx_done) begin
        txen_q <= 1'b0;
      end else if (ctrl_wr_c) begin
        txen_q <= busy_c ? (txen_q & data_in[0]) : data_in[0];
      end
      if (ctrl_wr_c) begin
        intmsk_q <= data_in[1];
      end
      intflag_q <= tx_done | (intflag_q & ~(ctrl_wr_c & data_in[2]));
      if (wr_c && (endereco == ADDR_DATA0)) begin
        data0_q <= data_in;
      end
      if (wr_c && (endereco == ADDR_DATA1)) begin
        data1_q <= data_in;
      end
    end
  end

  // Modulator state register and datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      OUT     <= IDLE_LEVEL;
      cyc_q   <= '0;
      dib_q   <= '0;
      snap0_q <= '0;
      snap1_q <= '0;
    end else begin
      state_q <= state_n;
      OUT     <= out_n;
      cyc_q   <= cyc_n;
      dib_q   <= dib_n;
      if (snap_load) begin
        snap0_q <= data0_q;
        snap1_q <= data1_q;
      end
    end
  end

  // Next state: clearing TXENABLE aborts from either byte state.
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE: begin
        if (txen_q) state_n = S_BYTE0;
      end
      S_BYTE0: begin
        if (!txen_q)         state_n = S_IDLE;
        else if (sym_last_c) state_n = S_BYTE1;
      end
      S_BYTE1: begin
        if (!txen_q)         state_n = S_IDLE;
        else if (sym_last_c) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs: next OUT sample, symbol/dibit counters, snapshot and completion strobes.
  always_comb begin
    out_n     = OUT;
    cyc_n     = cyc_q;
    dib_n     = dib_q;
    snap_load = 1'b0;
    tx_done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        out_n = IDLE_LEVEL;
        cyc_n = '0;
        dib_n = '0;
        if (txen_q) begin
          snap_load = 1'b1;
          out_n     = pam4_level(encode(data0_q), 2'd0);
        end
      end
      default: begin
        if (!txen_q) begin
          out_n = IDLE_LEVEL;
          cyc_n = '0;
          dib_n = '0;
        end else if (cyc_q == CYC_LAST) begin
          cyc_n = '0;
          dib_n = 2'(dib_q + 2'd1);
          if (dib_q == 2'd3) begin
            if (state_q == S_BYTE0) begin
              out_n = pam4_level(encode(snap1_q), 2'd0);
            end else begin
              out_n   = IDLE_LEVEL;
              tx_done = 1'b1;
            end
          end else begin
            out_n = pam4_level(encode(cur_byte_c), 2'(dib_q + 2'd1));
          end
        end else begin
          cyc_n = CYC_W'(cyc_q + 1'b1);
        end
      end
    endcase
  end

endmodule

// File: tb/tb_bsg_tx_core.sv
// Self-checking bench for bsg_tx_core: directed and random transfers against a time-based model.
module tb_bsg_tx_core;

  localparam int S = 4;
  localparam logic [7:0] IDLE = 8'h80;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid = 1'b0;
  logic       escrita = 1'b0;
  logic [1:0] endereco = 2'd0;
  logic [7:0] data_in = 8'd0;
  logic [7:0] data_out;
  logic       ready;
  logic [7:0] OUT;
  logic       BSG_INT;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: register image plus a transmission described by its start edge.
  logic       m_txen, m_msk, m_flag, m_act;
  logic [7:0] m_d0, m_d1, m_s0, m_s1;
  int         m_t0, m_abort;

  bsg_tx_core #(.SYM_CYCLES(S), .IDLE_LEVEL(IDLE)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .escrita(escrita), .endereco(endereco),
    .data_in(data_in), .data_out(data_out), .ready(ready), .OUT(OUT), .BSG_INT(BSG_INT)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, want, cyc);
    end
  endtask

  task automatic model_reset();
    m_txen = 0; m_msk = 0; m_flag = 0; m_act = 0;
    m_d0 = 0; m_d1 = 0; m_s0 = 0; m_s1 = 0; m_t0 = 0; m_abort = -1;
  endtask

  function automatic logic [7:0] ref_enc(input logic [7:0] b);
`ifdef BSG_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  // Expected OUT after edge number 'now'.
  function automatic logic [7:0] exp_out(input int now);
    int k, j, lvl;
    logic [7:0] bv;
    if (!m_act) return IDLE;
    if (m_abort >= 0 && now >= m_abort) return IDLE;
    k = now - m_t0;
    if (k < 0 || k >= 8 * S) return IDLE;
    bv  = ref_enc((k < 4 * S) ? m_s0 : m_s1);
    j   = (k / S) % 4;
    lvl = ((int'(bv) >> (6 - 2 * j)) & 3) * 85;
    return 8'(lvl);
  endfunction

  // Retire a finished or aborted transmission as of edge 'now'.
  task automatic sync(input int now);
    if (m_act) begin
      if (m_abort >= 0 && now >= m_abort) begin
        m_act = 0; m_abort = -1;
      end else if (now - m_t0 >= 8 * S) begin
        m_act = 0; m_flag = 1; m_txen = 0;
      end
    end
  endtask

  task automatic bus(input logic wr, input logic [1:0] a, input logic [7:0] d);
    int e;
    logic busy;
    logic [7:0] ev;
    @(negedge clk);
    valid = 1; escrita = wr; endereco = a; data_in = d;
    @(posedge clk); #1;
    e = cyc;
    chk("ready_pulse", {7'd0, ready}, 8'd1);
    sync(e - 1);
    busy = m_act && (e - 1 >= m_t0);
    case (a)
      2'd0:    ev = {4'd0, busy, m_flag, m_msk, m_txen};
      2'd1:    ev = m_d0;
      2'd2:    ev = m_d1;
      default: ev = 8'h00;
    endcase
    if (!wr) chk("read_data", data_out, ev);
    else begin
      case (a)
        2'd0: begin
          if (busy) begin
            if (!d[0] && m_txen) begin m_txen = 0; m_abort = e + 1; end
          end else if (d[0]) begin
            m_txen = 1; m_act = 1; m_t0 = e + 1; m_s0 = m_d0; m_s1 = m_d1; m_abort = -1;
          end else m_txen = 0;
          m_msk = d[1];
          if (d[2]) m_flag = 0;
        end
        2'd1: m_d0 = d;
        2'd2: m_d1 = d;
        default: ;
      endcase
    end
    @(negedge clk);
    valid = 0;
  endtask

  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      sync(cyc);
      chk("out_sample", OUT, exp_out(cyc));
      chk("bsg_int", {7'd0, BSG_INT}, {7'd0, m_flag & m_msk});
    end
  endtask

  initial begin
    logic [7:0] r0, r1;
    logic mk;
    model_reset();
    rst_n = 1;
    #2 rst_n = 0;
    #6;
    chk("rst_out", OUT, IDLE);
    chk("rst_int", {7'd0, BSG_INT}, 8'd0);
    chk("rst_ready", {7'd0, ready}, 8'd0);
    chk("rst_dout", data_out, 8'd0);
    @(negedge clk); rst_n = 1;
    bus(0, 2'd0, 8'h00);

    // Register access, unmapped address, data_out cleared outside ready.
    bus(1, 2'd1, 8'hB4);
    bus(0, 2'd1, 8'h00);
    @(posedge clk); #1;
    chk("dout_idle", data_out, 8'd0);
    chk("ready_low", {7'd0, ready}, 8'd0);
    bus(1, 2'd3, 8'h5A);
    bus(0, 2'd3, 8'h00);

    // Directed transmission B4/00 with interrupt enabled.
    bus(1, 2'd2, 8'h00);
    bus(1, 2'd0, 8'h03);
    watch(8 * S + 2);
    bus(0, 2'd0, 8'h00);

    // W1C of INTFLAG, then a run with INTMSK=0.
    bus(1, 2'd0, 8'h06);
    watch(2);
    bus(0, 2'd0, 8'h00);
    bus(1, 2'd0, 8'h01);
    watch(8 * S + 4);
    bus(0, 2'd0, 8'h00);
    bus(1, 2'd0, 8'h04);

    // Data write during BYTE0 is stored but not sent; then abort inside BYTE1.
    bus(1, 2'd1, 8'h3C);
    bus(1, 2'd0, 8'h03);
    watch(6);
    bus(1, 2'd2, 8'hFF);
    watch(10);
    bus(0, 2'd2, 8'h00);
    watch(4);
    bus(1, 2'd0, 8'h02);
    watch(4);
    bus(0, 2'd0, 8'h00);

    // Random payloads, with a restart attempt and a mid-TX read.
    for (int it = 0; it < 4; it++) begin
      r0 = 8'($urandom);
      r1 = 8'($urandom);
      mk = 1'($urandom);
      bus(1, 2'd1, r0);
      bus(1, 2'd2, r1);
      bus(1, 2'd0, {6'd0, mk, 1'b1});
      watch(10);
      if (it == 1) bus(1, 2'd0, {6'd0, mk, 1'b1});
      if (it == 2) bus(0, 2'd2, 8'h00);
      watch(8 * S);
      bus(0, 2'd0, 8'h00);
      bus(1, 2'd0, {5'd0, 1'b1, mk, 1'b0});
    end

    // Back-to-back transfers with valid held throughout.
    @(negedge clk);
    valid = 1; escrita = 1; endereco = 2'd1; data_in = 8'h11;
    @(posedge clk); #1; chk("b2b_ready0", {7'd0, ready}, 8'd1);
    @(negedge clk); endereco = 2'd2; data_in = 8'h22;
    @(posedge clk); #1; chk("b2b_gap0", {7'd0, ready}, 8'd0);
    @(posedge clk); #1; chk("b2b_ready1", {7'd0, ready}, 8'd1);
    @(negedge clk); endereco = 2'd0; data_in = 8'h02;
    @(posedge clk); #1; chk("b2b_gap1", {7'd0, ready}, 8'd0);
    @(posedge clk); #1; chk("b2b_ready2", {7'd0, ready}, 8'd1);
    @(negedge clk); valid = 0;
    m_d0 = 8'h11; m_d1 = 8'h22; m_msk = 1; m_txen = 0;
    bus(0, 2'd1, 8'h00);
    bus(0, 2'd2, 8'h00);
    bus(0, 2'd0, 8'h00);

    // Reset in the middle of a transmission with the interrupt asserted.
    bus(1, 2'd0, 8'h03);
    watch(8 * S + 2);
    bus(1, 2'd0, 8'h03);
    watch(5);
    @(negedge clk); rst_n = 0; #1;
    model_reset();
    chk("midrst_out", OUT, IDLE);
    chk("midrst_int", {7'd0, BSG_INT}, 8'd0);
    @(negedge clk); rst_n = 1;
    for (int a = 0; a < 4; a++) bus(0, 2'(a), 8'h00);
    watch(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
